// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed seven-segment driver. A binary value handed over on a
// load/ready handshake is converted to BCD one bit per cycle (shift-add-3).
// The finished BCD digits are scanned one at a time onto a shared segment bus.
// The scan supports per-digit blanking, leading-zero suppression and
// selectable output polarity.
module seg7_scan_driver #(
    parameter int BIN_W      = 16,
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      value,
    input  logic                  load,
    output logic                  ready,
    output logic                  busy,
    input  logic                  suppress_zeros,
    input  logic [NUM_DIGITS-1:0] blank,
    output logic [6:0]            segment,
    output logic [NUM_DIGITS-1:0] digit_sel
);

    // ------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------
    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int ITER_W = $clog2(BIN_W + 1);
    localparam int PRE_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam real LOG2_10 = 3.321928094887362;

    localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                           : {NUM_DIGITS{1'b0}};

    // Elaboration-time sanity checks on the parameter set.
    generate
        if (NUM_DIGITS < 2) begin : g_bad_num_digits
            $error("seg7_scan_driver: NUM_DIGITS must be at least 2");
        end
        if (SCAN_DIV < 2) begin : g_bad_scan_div
            $error("seg7_scan_driver: SCAN_DIV must be at least 2");
        end
        // 2^BIN_W <= 10^NUM_DIGITS  <=>  BIN_W <= NUM_DIGITS * log2(10)
        if (real'(BIN_W) > real'(NUM_DIGITS) * LOG2_10) begin : g_bad_bin_w
            $error("seg7_scan_driver: BIN_W too wide for NUM_DIGITS decimal digits");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Segment decode, active-high gfedcba
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'b0111111;
            4'd1:    pat = 7'b0000110;
            4'd2:    pat = 7'b1011011;
            4'd3:    pat = 7'b1001111;
            4'd4:    pat = 7'b1100110;
            4'd5:    pat = 7'b1101101;
            4'd6:    pat = 7'b1111101;
            4'd7:    pat = 7'b0000111;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1100111;
            default: pat = 7'b0000000;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------
    // Conversion engine state
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    // {bcd accumulator, binary remainder}, shifted left once per iteration
    logic [WORK_W-1:0]   work_q, work_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [BCD_W-1:0]    disp_q, disp_d;

    logic [WORK_W-1:0]   work_adj;
    logic [WORK_W-1:0]   work_shift;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
    always_comb begin
        work_adj = work_q;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (work_q[BIN_W + 4*n +: 4] >= 4'd5) begin
                work_adj[BIN_W + 4*n +: 4] = work_q[BIN_W + 4*n +: 4] + 4'd3;
            end
        end
        work_shift = work_adj << 1;
    end

    // Conversion FSM: next state, working register and display register update.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d = state_q;
        work_d  = work_q;
        iter_d  = iter_q;
        disp_d  = disp_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    work_d  = {{BCD_W{1'b0}}, value};
                    iter_d  = '0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                work_d = work_shift;
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(BIN_W - 1)) begin
                    disp_d  = work_shift[WORK_W-1 -: BCD_W];
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Conversion FSM and display register flops.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            iter_q  <= '0;
            // NOTE: the display register must be reset so an aborted
            // conversion can never leave stale or partial digits on show.
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            iter_q  <= iter_d;
            disp_q  <= disp_d;
        end
    end

    assign busy  = (state_q == ST_CONVERT);
    assign ready = ~busy;

    // ------------------------------------------------------------------
    // Scan timing: prescaler and digit index
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pre_wrap;

    // Prescaler counts 0..SCAN_DIV-1; each wrap steps the digit index.
    always_comb begin
        pre_wrap = (pre_q == PRE_W'(SCAN_DIV - 1));
        pre_d    = pre_wrap ? '0 : pre_q + PRE_W'(1);
        idx_d    = idx_q;
        if (pre_wrap) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Prescaler and digit index flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit rendering and output registers
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] upper_zero;   // nibbles i..NUM_DIGITS-1 all zero
    logic [3:0]            cur_nib;
    logic                  cur_hidden;
    logic [6:0]            cur_pat;
    logic [NUM_DIGITS-1:0] cur_onehot;
    logic [6:0]            seg_d, seg_q;
    logic [NUM_DIGITS-1:0] sel_d, sel_q;

    // Render the current digit from the display register and live controls.
    always_comb begin
        upper_zero                 = '0;
        upper_zero[NUM_DIGITS-1]   = (disp_q[BCD_W-1 -: 4] == 4'd0);
        for (int n = NUM_DIGITS - 2; n >= 0; n--) begin
            upper_zero[n] = upper_zero[n+1] && (disp_q[4*n +: 4] == 4'd0);
        end

        cur_nib    = disp_q[4*idx_q +: 4];
        // Digit 0 is never zero-suppressed so a value of 0 still shows "0".
        cur_hidden = blank[idx_q] ||
                     (suppress_zeros && (idx_q != '0) && upper_zero[idx_q]);
        cur_pat    = cur_hidden ? 7'b0000000 : seg7_decode(cur_nib);

        cur_onehot         = '0;
        cur_onehot[idx_q]  = 1'b1;

        seg_d = ACTIVE_LOW ? ~cur_pat    : cur_pat;
        sel_d = ACTIVE_LOW ? ~cur_onehot : cur_onehot;
    end

    // Registered segment and digit-select outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_q <= SEG_OFF;
            sel_q <= SEL_OFF;
        end else begin
            seg_q <= seg_d;
            sel_q <= sel_d;
        end
    end

    assign segment   = seg_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver (BIN_W=16, NUM_DIGITS=8, SCAN_DIV=4,
// active-low outputs). A decimal-arithmetic model predicts segment, digit_sel,
// busy and ready for every cycle; literal expectations pin key digits.
module tb_seg7_scan_driver;

    localparam int BIN_W = 16;
    localparam int ND    = 8;
    localparam int SD    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   value = '0;
    logic          load  = 1'b0;
    logic          ready;
    logic          busy;
    logic          suppress_zeros = 1'b0;
    logic [ND-1:0] blank = '0;
    logic [6:0]    segment;
    logic [ND-1:0] digit_sel;

    seg7_scan_driver #(
        .BIN_W      (BIN_W),
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .value          (value),
        .load           (load),
        .ready          (ready),
        .busy           (busy),
        .suppress_zeros (suppress_zeros),
        .blank          (blank),
        .segment        (segment),
        .digit_sel      (digit_sel)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Active-high gfedcba patterns for decimal digits 0..9.
    localparam logic [6:0] PAT [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1100111
    };

    // Active-low segment drive for decimal position i of number num.
    function automatic logic [6:0] model_seg(input int num, input int i,
                                             input logic [ND-1:0] bl, input logic sz);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (bl[i] || (sz && i != 0 && num < p)) return 7'h7F;
        return ~PAT[(num / p) % 10];
    endfunction

    // ------------------------------------------------------------------
    // Model: displayed number, cycles since reset, remaining busy cycles.
    // ------------------------------------------------------------------
    int         m_disp = 0;
    int         m_pend = 0;
    int         m_left = 0;
    int         m_cyc  = 0;
    int         m_idx  = 0;
    logic [6:0]    e_seg;
    logic [ND-1:0] e_sel;
    logic          e_busy;
    bit            e_valid = 1'b0;

    // Compare outputs against the previous prediction, then predict the next edge.
    always @(negedge clock) begin
        if (e_valid) begin
            check("segment",   segment,   e_seg);
            check("digit_sel", digit_sel, e_sel);
            check("busy",      busy,      e_busy);
            check("ready",     ready,     !e_busy);
        end
        if (reset) begin
            m_disp = 0;
            m_left = 0;
            m_cyc  = 0;
            e_seg  = 7'h7F;
            e_sel  = '1;
            e_busy = 1'b0;
        end else begin
            m_idx = (m_cyc / SD) % ND;
            e_seg = model_seg(m_disp, m_idx, blank, suppress_zeros);
            e_sel = ~(ND'(1) << m_idx);
            m_cyc++;
            if (m_left == 0) begin
                if (load) begin
                    m_pend = int'(value);
                    m_left = BIN_W;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_disp = m_pend;
            end
            e_busy = (m_left != 0);
        end
        e_valid = 1'b1;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_load(input int v);
        int guard;
        guard = 0;
        while (!ready && guard < 200) begin
            tick(1);
            guard++;
        end
        check("ready_before_load", ready, 1);
        value = 16'(v);
        load  = 1'b1;
        tick(1);
        load  = 1'b0;
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (busy) n++;
            else break;
        end
        tick(1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", ok, 1);
        tick(1);
    endtask

    task automatic expect_digit(input string name, input int i, input logic [6:0] exp);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < ND * SD + 8; k++) begin
            @(negedge clock);
            if (digit_sel == ~(ND'(1) << i)) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_found"}, ok, 1);
        check(name, segment, exp);
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    int n_busy;

    initial begin
        // Reset held for three cycles.
        reset = 1'b1;
        tick(3);
        check("rst_segment", segment,   7'h7F);
        check("rst_sel",     digit_sel, 8'hFF);
        check("rst_ready",   ready,     1);
        check("rst_busy",    busy,      0);
        reset = 1'b0;
        tick(1);
        check("first_digit_sel", digit_sel, 8'hFE);
        check("first_digit_seg", segment,   7'b1000000);
        tick(40);

        // 1234, suppress off.
        do_load(1234);
        measure_busy(n_busy);
        check("busy_len_1234", n_busy, 16);
        expect_digit("d2_1234", 2, 7'b0100100);
        expect_digit("d3_1234", 3, 7'b1111001);
        expect_digit("d0_1234", 0, 7'b0011001);
        expect_digit("d7_1234", 7, 7'b1000000);

        // 65535 with leading-zero suppression, then 0.
        suppress_zeros = 1'b1;
        do_load(65535);
        wait_idle();
        expect_digit("d4_65535", 4, 7'b0000010);
        expect_digit("d5_65535", 5, 7'h7F);
        expect_digit("d7_65535", 7, 7'h7F);
        expect_digit("d0_65535", 0, 7'b0010010);
        do_load(0);
        wait_idle();
        expect_digit("d0_zero", 0, 7'b1000000);
        expect_digit("d1_zero", 1, 7'h7F);

        // 1005 with digit 2 forced blank; internal zero stays visible.
        blank = 8'b0000_0100;
        do_load(1005);
        wait_idle();
        expect_digit("d3_1005", 3, 7'b1111001);
        expect_digit("d2_1005", 2, 7'h7F);
        expect_digit("d1_1005", 1, 7'b1000000);
        expect_digit("d0_1005", 0, 7'b0010010);
        expect_digit("d4_1005", 4, 7'h7F);
        blank          = '0;
        suppress_zeros = 1'b0;

        // Load pulsed while busy is ignored.
        do_load(777);
        tick(4);
        value = 16'd4321;
        load  = 1'b1;
        tick(1);
        load  = 1'b0;
        wait_idle();
        expect_digit("d3_777", 3, 7'b1000000);
        expect_digit("d2_777", 2, 7'b1111000);
        expect_digit("d0_777", 0, 7'b1111000);

        // Load held through busy is taken on the edge ready returns.
        do_load(100);
        value = 16'd321;
        load  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (!busy) break;
        end
        @(posedge clock);
        #1;
        check("accept_on_ready", busy, 1);
        load = 1'b0;
        wait_idle();
        expect_digit("d2_321", 2, 7'b0110000);
        expect_digit("d0_321", 0, 7'b1111001);

        // Reset eight cycles into a 9999 conversion.
        do_load(9999);
        tick(7);
        reset = 1'b1;
        tick(1);
        check("midrst_busy",  busy,  0);
        check("midrst_ready", ready, 1);
        reset = 1'b0;
        expect_digit("d3_after_rst", 3, 7'b1000000);
        expect_digit("d0_after_rst", 0, 7'b1000000);
        do_load(42);
        measure_busy(n_busy);
        check("busy_len_42", n_busy, 16);
        expect_digit("d1_42", 1, 7'b0011001);
        expect_digit("d0_42", 0, 7'b0100100);

        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
